// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter with hazard lookup
// Optional round-robin tie-break enabled by defining WB_RR_ARB_EN (default: load unit wins ties).
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_sel,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              haz_rs1,
  output logic              haz_rs2
);

  logic              alu_full, ld_full;
  logic [ADDR_W-1:0] alu_rd_q, ld_rd_q;
  logic [DATA_W-1:0] alu_data_q, ld_data_q;
  logic              alu_grant, ld_grant;
  logic              alu_load, ld_load;

`ifdef WB_RR_ARB_EN
  // ptr_ld set means the load unit is preferred on the next tie
  logic ptr_ld;

  always_comb begin
    alu_grant = alu_full & (~ld_full | ~ptr_ld);
    ld_grant  = ld_full & (~alu_full | ptr_ld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_ld <= 1'b0;
    end else if (alu_grant) begin
      ptr_ld <= 1'b1;
    end else if (ld_grant) begin
      ptr_ld <= 1'b0;
    end
  end
`else
  always_comb begin
    alu_grant = alu_full & ~ld_full;
    ld_grant  = ld_full;
  end
`endif

  // A granted entry frees its slot at the same edge, so a requester can stream one per cycle
  assign alu_ready = ~alu_full | alu_grant;
  assign ld_ready  = ~ld_full | ld_grant;

  // Writes to x0 are accepted but never occupy a holding entry
  assign alu_load = alu_valid & alu_ready & (alu_rd != '0);
  assign ld_load  = ld_valid & ld_ready & (ld_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full   <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
    end else if (alu_load) begin
      alu_full   <= 1'b1;
      alu_rd_q   <= alu_rd;
      alu_data_q <= alu_data;
    end else if (alu_grant) begin
      alu_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_full   <= 1'b0;
      ld_rd_q   <= '0;
      ld_data_q <= '0;
    end else if (ld_load) begin
      ld_full   <= 1'b1;
      ld_rd_q   <= ld_rd;
      ld_data_q <= ld_data;
    end else if (ld_grant) begin
      ld_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_sel   <= '0;
      rf_wdata <= '0;
    end else if (ld_grant) begin
      rf_we    <= 1'b1;
      rf_sel   <= ld_rd_q;
      rf_wdata <= ld_data_q;
    end else if (alu_grant) begin
      rf_we    <= 1'b1;
      rf_sel   <= alu_rd_q;
      rf_wdata <= alu_data_q;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // A source is hazardous while its value sits in a holding entry or on the write port
  always_comb begin
    haz_rs1 = (chk_rs1 != '0) &&
              ((alu_full && (alu_rd_q == chk_rs1)) ||
               (ld_full && (ld_rd_q == chk_rs1)) ||
               (rf_we && (rf_sel == chk_rs1)));
    haz_rs2 = (chk_rs2 != '0) &&
              ((alu_full && (alu_rd_q == chk_rs2)) ||
               (ld_full && (ld_rd_q == chk_rs2)) ||
               (rf_we && (rf_sel == chk_rs2)));
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: writeback data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width in bits (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports alu_valid  input  1; alu_rd  input  ADDR_W; alu_data  input  DATA_W: ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted when alu_valid & alu_ready at a clock edge.
REQ-007 SHALL have ports ld_valid  input  1; ld_rd  input  ADDR_W; ld_data  input  DATA_W: load-unit writeback request.
REQ-008 SHALL have port ld_ready  output  1  load request accepted when ld_valid & ld_ready at a clock edge.
REQ-009 SHALL have ports rf_we  output  1; rf_sel  output  ADDR_W; rf_wdata  output  DATA_W: register-file write port (write_enable/select/data_in), all registered.
REQ-010 SHALL have ports chk_rs1, chk_rs2  input  ADDR_W: decode-stage source indices.
REQ-011 SHALL have ports haz_rs1, haz_rs2  output  1: source has a write still pending in this block.

Function
REQ-012 SHALL hold one holding entry per requester (full flag, rd, data).
REQ-013 SHALL capture an accepted request into its holding entry at the accepting edge; accepted requests with rd==0 SHALL be dropped and SHALL NOT set full.
REQ-014 SHALL compute the grant combinationally from holding full flags and the priority pointer only, never from alu_valid or ld_valid.
REQ-015 SHALL set xx_ready = ~xx_full | xx_grant, giving one accept per cycle per requester.
REQ-016 SHALL grant at most one full entry per cycle; on a grant edge, rf_we<=1 and rf_sel/rf_wdata<=winner's rd/data, and the winner's full flag clears unless it is reloaded at the same edge.
REQ-017 SHALL set rf_we<=0 at any edge with no grant, leaving rf_sel/rf_wdata unchanged.
REQ-018 Latency SHALL be: accept at edge E, rf_we high in the cycle after edge E+1 if uncontested (register-file write at edge E+2).
REQ-019 With both entries full, the winner SHALL be chosen per REQ-029/REQ-030; the loser SHALL stay full with rd/data unchanged.
REQ-020 SHALL guarantee no starvation: a full entry SHALL be granted within 2 cycles under round-robin.
REQ-021 SHALL assert haz_rsN when chk_rsN!=0 and chk_rsN equals the rd of a full holding entry or equals rf_sel while rf_we=1.
REQ-022 SHALL force haz_rsN=0 when chk_rsN==0.
REQ-023 SHALL NOT order writes between requesters; same-rd ordering across requesters is the issuing stage's responsibility.
REQ-024 SHALL keep writes from one requester in acceptance order.

Reset
REQ-025 On rst_n low, SHALL immediately clear both full flags and rf_we, set rf_sel=0 and rf_wdata=0, and reset the priority pointer to ALU-first.
REQ-026 While reset is asserted, alu_ready=ld_ready=1 and haz_rs1=haz_rs2=0; handshakes SHALL be ignored.
REQ-027 Reset mid-operation SHALL discard pending writes; no partial rf_we pulse SHALL follow reset release.
REQ-028 SHALL sample the first handshake at the first rising clk edge after rst_n goes high.

Configuration
REQ-029 With macro WB_RR_ARB_EN defined, contested grants SHALL alternate: the pointer flips to the other requester after each grant; the first tie after reset goes to ALU.
REQ-030 Without WB_RR_ARB_EN, the load unit SHALL always win ties and the pointer logic SHALL be absent; REQ-020 does not apply.

Verification
REQ-031 Uncontested write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> rf_we=1, rf_sel=5, rf_wdata=0xDEADBEEF exactly one cycle, two edges after accept.
REQ-032 x0 drop: ld_valid=1, ld_rd=0, ld_data=0x1234 -> ld_ready=1, rf_we never asserts, haz_rs1=0 with chk_rs1=0.
REQ-033 Contention with WB_RR_ARB_EN: both valid continuously, rd=1 (ALU)/rd=2 (LD) -> rf_sel sequence 1,2,1,2 with rf_we=1 every cycle; without the macro -> rf_sel always 2 and ALU stalled with alu_ready=0.
REQ-034 Hazard: accept ld_rd=7, chk_rs2=7 -> haz_rs2=1 from accept until the cycle after rf_we drops for rf_sel=7.
REQ-035 Back-to-back single requester: alu_valid=1 for 4 cycles, rd=3..6 -> 4 consecutive rf_we cycles, rf_sel 3,4,5,6, alu_ready never low.
REQ-036 Reset mid-flight: both entries full, pull rst_n low asynchronously -> rf_we=0 and ready=1 before the next edge; no write after release.
